// File: rtl/cache_pkg.sv
// Shared types for the set-associative cache: bus ops, line status,
// controller states and the stored line layout.
package cache_pkg;

  localparam int ADDR_W  = 16;
  localparam int INDEX_W = 4;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = ADDR_W - INDEX_W;

  typedef enum logic [1:0] {
    Op_INVALID,
    Op_READ,
    Op_WRITE
  } Op;

  typedef enum logic [1:0] {
    Status_INVALID,
    Status_CLEAN,
    Status_DIRTY
  } Status;

  typedef enum logic [1:0] {
    State_READY,
    State_WRITEBACK,
    State_FILL,
    State_FLUSH
  } State;

  typedef struct packed {
    Status              status;
    logic [TAG_W-1:0]   tag;
    logic [DATA_W-1:0]  data;
  } Line;

endpackage

// File: rtl/mem_bus.sv
// Request/response memory bus. slave: req in, rsp out.
// master: req out, rsp in.
interface MemBus #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  import cache_pkg::*;

  Op                     req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  rsp_vld;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport slave (
    input  req_op, req_addr, req_data,
    output rsp_vld, rsp_data
  );

  modport master (
    output req_op, req_addr, req_data,
    input  rsp_vld, rsp_data
  );
endinterface

// File: rtl/cache_lru.sv
// Age-based replacement for one set: ages/valid/touched way in,
// updated ages and victim way out. Ages stay a permutation.
module cache_lru #(
  parameter int NUM_WAYS = 4
) (
  input  logic [NUM_WAYS-1:0][$clog2(NUM_WAYS)-1:0] ages,
  input  logic [NUM_WAYS-1:0]                       valid,
  input  logic [$clog2(NUM_WAYS)-1:0]               way,
  output logic [NUM_WAYS-1:0][$clog2(NUM_WAYS)-1:0] ages_n,
  output logic [$clog2(NUM_WAYS)-1:0]               victim
);
  localparam int WW = $clog2(NUM_WAYS);

  always_comb begin
    ages_n = ages;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (i == int'(way))
        ages_n[i] = '0;
      else if (ages[i] < ages[way])
        ages_n[i] = ages[i] + 1'b1;
    end
  end

  // Descending scans so the lowest-numbered match wins;
  // an invalid way overrides the oldest way.
  always_comb begin
    victim = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--)
      if (ages[i] == WW'(NUM_WAYS - 1))
        victim = WW'(i);
    for (int i = NUM_WAYS - 1; i >= 0; i--)
      if (!valid[i])
        victim = WW'(i);
  end

endmodule

// File: rtl/set_assoc_cache.sv
// Write-back set-associative cache, one word per line.
// rx_bp: upstream slave, tx_bp: downstream master, flush_req/done, busy.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int NUM_WAYS    = 4,
  parameter int INDEX_WIDTH = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  MemBus.slave  rx_bp,
  MemBus.master tx_bp,
  input  logic  flush_req,
  output logic  flush_done,
  output logic  busy
);
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;
  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int WW        = $clog2(NUM_WAYS);

  typedef logic [NUM_WAYS-1:0][WW-1:0] ages_t;

  Line   lines [SETS][NUM_WAYS];
  ages_t ages  [SETS];

  State state, state_n;
  Op                       c_op;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic [DATA_WIDTH-1:0]   c_data;
  logic [WW-1:0]           c_way;
  logic [INDEX_WIDTH+WW-1:0] scan;

  logic [INDEX_WIDTH-1:0] r_idx, c_idx, s_idx, l_idx;
  logic [TAG_WIDTH-1:0]   r_tag, c_tag;
  logic [WW-1:0]          s_way, hway, l_way, victim;
  logic [NUM_WAYS-1:0]    valid;
  ages_t                  ages_n;
  logic                   req, hit;
  Line                    vline;

  assign r_idx = rx_bp.req_addr[INDEX_WIDTH-1:0];
  assign r_tag = rx_bp.req_addr[ADDR_WIDTH-1:INDEX_WIDTH];
  assign c_idx = c_addr[INDEX_WIDTH-1:0];
  assign c_tag = c_addr[ADDR_WIDTH-1:INDEX_WIDTH];
  assign s_idx = scan[INDEX_WIDTH+WW-1:WW];
  assign s_way = scan[WW-1:0];
  assign req   = rx_bp.req_op != Op_INVALID;

  always_comb begin
    hit  = 1'b0;
    hway = '0;
    for (int i = 0; i < NUM_WAYS; i++)
      if (lines[r_idx][i].status != Status_INVALID &&
          lines[r_idx][i].tag == r_tag) begin
        hit  = 1'b1;
        hway = WW'(i);
      end
  end

  // The replacement block looks at the request set in READY
  // and at the captured set while filling.
  assign l_idx = (state == State_FILL) ? c_idx : r_idx;
  assign l_way = (state == State_FILL) ? c_way : hway;

  always_comb begin
    valid = '0;
    for (int i = 0; i < NUM_WAYS; i++)
      valid[i] = lines[l_idx][i].status != Status_INVALID;
  end

  cache_lru #(.NUM_WAYS(NUM_WAYS)) u_lru (
    .ages   (ages[l_idx]),
    .valid  (valid),
    .way    (l_way),
    .ages_n (ages_n),
    .victim (victim)
  );

  assign vline = lines[r_idx][victim];

  always_comb begin
    state_n = state;
    unique case (state)
      State_READY:
        if (req) begin
          if (!hit)
            state_n = (vline.status == Status_DIRTY) ?
                      State_WRITEBACK : State_FILL;
        end else if (flush_req) begin
          state_n = State_FLUSH;
        end
      State_WRITEBACK: state_n = State_FILL;
      State_FILL:
        if (tx_bp.rsp_vld) state_n = State_READY;
      State_FLUSH:
        if (&scan) state_n = State_READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= State_READY;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= state_n != State_READY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++) begin
          lines[s][w] <= '0;
          ages[s][w]  <= WW'(w);
        end
      c_op             <= Op_INVALID;
      c_addr           <= '0;
      c_data           <= '0;
      c_way            <= '0;
      scan             <= '0;
      rx_bp.rsp_vld    <= 1'b0;
      rx_bp.rsp_data   <= '0;
      tx_bp.req_op     <= Op_INVALID;
      tx_bp.req_addr   <= '0;
      tx_bp.req_data   <= '0;
      flush_done       <= 1'b0;
    end else begin
      rx_bp.rsp_vld <= 1'b0;
      tx_bp.req_op  <= Op_INVALID;
      flush_done    <= 1'b0;
      unique case (state)
        State_READY:
          if (req) begin
            c_op   <= rx_bp.req_op;
            c_addr <= rx_bp.req_addr;
            c_data <= rx_bp.req_data;
            if (hit) begin
              ages[r_idx]   <= ages_n;
              rx_bp.rsp_vld <= 1'b1;
              if (rx_bp.req_op == Op_WRITE) begin
                lines[r_idx][hway].data   <= rx_bp.req_data;
                lines[r_idx][hway].status <= Status_DIRTY;
                rx_bp.rsp_data            <= rx_bp.req_data;
              end else begin
                rx_bp.rsp_data <= lines[r_idx][hway].data;
              end
            end else begin
              c_way <= victim;
              if (vline.status == Status_DIRTY) begin
                tx_bp.req_op   <= Op_WRITE;
                tx_bp.req_addr <= {vline.tag, r_idx};
                tx_bp.req_data <= vline.data;
              end else begin
                tx_bp.req_op   <= Op_READ;
                tx_bp.req_addr <= rx_bp.req_addr;
                tx_bp.req_data <= '0;
              end
            end
          end else if (flush_req) begin
            scan <= '0;
          end
        State_WRITEBACK: begin
          tx_bp.req_op   <= Op_READ;
          tx_bp.req_addr <= c_addr;
          tx_bp.req_data <= '0;
        end
        State_FILL:
          if (tx_bp.rsp_vld) begin
            ages[c_idx]   <= ages_n;
            rx_bp.rsp_vld <= 1'b1;
            if (c_op == Op_WRITE) begin
              lines[c_idx][c_way] <= Line'{status: Status_DIRTY,
                                           tag: c_tag, data: c_data};
              rx_bp.rsp_data <= c_data;
            end else begin
              lines[c_idx][c_way] <= Line'{status: Status_CLEAN,
                                           tag: c_tag,
                                           data: tx_bp.rsp_data};
              rx_bp.rsp_data <= tx_bp.rsp_data;
            end
          end
        State_FLUSH: begin
          scan <= scan + 1'b1;
          if (lines[s_idx][s_way].status == Status_DIRTY) begin
            tx_bp.req_op   <= Op_WRITE;
            tx_bp.req_addr <= {lines[s_idx][s_way].tag, s_idx};
            tx_bp.req_data <= lines[s_idx][s_way].data;
            lines[s_idx][s_way].status <= Status_CLEAN;
          end
          if (&scan) flush_done <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: hits, misses, eviction,
// flush and reset abandonment against hand-computed values.
module tb_set_assoc_cache;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_req;
  logic flush_done;
  logic busy;

  int nerr = 0;
  int nchk = 0;
  int cycles = 0;
  int rxv_cnt = 0;

  Op           txq_op   [$];
  logic [15:0] txq_addr [$];
  logic [31:0] txq_data [$];

  MemBus #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) rx ();
  MemBus #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) tx ();

  set_assoc_cache #(
    .NUM_WAYS(4), .INDEX_WIDTH(4),
    .ADDR_WIDTH(16), .DATA_WIDTH(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_bp      (rx),
    .tx_bp      (tx),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .busy       (busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    cycles <= cycles + 1;
    if (tx.req_op != Op_INVALID) begin
      txq_op.push_back(tx.req_op);
      txq_addr.push_back(tx.req_addr);
      txq_data.push_back(tx.req_data);
    end
    if (rx.rsp_vld) rxv_cnt <= rxv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; returns one cycle later with req dropped.
  task automatic send(input Op op, input logic [15:0] a,
                      input logic [31:0] d);
    rx.req_op   = op;
    rx.req_addr = a;
    rx.req_data = d;
    @(negedge clk);
    rx.req_op   = Op_INVALID;
  endtask

  // Downstream reply after lat cycles; returns when rx rsp is due.
  task automatic fill(input logic [31:0] d, input int lat);
    repeat (lat) @(negedge clk);
    tx.rsp_vld  = 1'b1;
    tx.rsp_data = d;
    @(negedge clk);
    tx.rsp_vld  = 1'b0;
  endtask

  task automatic do_flush(output int cnt);
    cnt = 0;
    flush_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        flush_req = 1'b0;
        chk("flush_busy", 32'(busy), 32'd1);
      end
      if (flush_done) break;
    end
  endtask

  int t0, t1, c0, n, r0;

  initial begin
    rst_n       = 1'b0;
    flush_req   = 1'b0;
    rx.req_op   = Op_INVALID;
    rx.req_addr = '0;
    rx.req_data = '0;
    tx.rsp_vld  = 1'b0;
    tx.rsp_data = '0;
    cyc(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_vld", 32'(rx.rsp_vld), 32'd0);
    chk("rst_rx_data", rx.rsp_data, 32'd0);
    chk("rst_fdone", 32'(flush_done), 32'd0);
    chk("rst_tx_op", 32'(tx.req_op), 32'(Op_INVALID));
    chk("rst_tx_addr", 32'(tx.req_addr), 32'd0);
    chk("rst_tx_data", tx.req_data, 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // read miss, clean victim, downstream latency 2
    c0 = cycles;
    send(Op_READ, 16'h0013, '0);
    chk("rm_tx_op", 32'(tx.req_op), 32'(Op_READ));
    chk("rm_tx_addr", 32'(tx.req_addr), 32'h0013);
    chk("rm_busy", 32'(busy), 32'd1);
    chk("rm_no_rsp", 32'(rx.rsp_vld), 32'd0);
    cyc(1);
    chk("rm_tx_idle", 32'(tx.req_op), 32'(Op_INVALID));
    fill(32'hAAAA0001, 1);
    chk("rm_rsp_vld", 32'(rx.rsp_vld), 32'd1);
    chk("rm_rsp_data", rx.rsp_data, 32'hAAAA0001);
    chk("rm_latency", 32'(cycles - c0), 32'd4);
    chk("rm_busy_done", 32'(busy), 32'd0);
    cyc(1);
    chk("rm_rsp_pulse", 32'(rx.rsp_vld), 32'd0);

    t0 = txq_op.size();
    send(Op_READ, 16'h0013, '0);
    chk("rh_rsp_vld", 32'(rx.rsp_vld), 32'd1);
    chk("rh_rsp_data", rx.rsp_data, 32'hAAAA0001);
    chk("rh_busy", 32'(busy), 32'd0);
    cyc(1);
    chk("rh_no_tx", 32'(txq_op.size()), 32'(t0));

    // write miss installs dirty with written data
    send(Op_WRITE, 16'h0023, 32'h12345678);
    chk("wm_tx_op", 32'(tx.req_op), 32'(Op_READ));
    chk("wm_tx_addr", 32'(tx.req_addr), 32'h0023);
    fill(32'h0, 0);
    chk("wm_rsp_vld", 32'(rx.rsp_vld), 32'd1);
    chk("wm_rsp_data", rx.rsp_data, 32'h12345678);
    t1 = txq_op.size();
    send(Op_READ, 16'h0023, '0);
    chk("wr_rsp_vld", 32'(rx.rsp_vld), 32'd1);
    chk("wr_rsp_data", rx.rsp_data, 32'h12345678);
    cyc(1);
    chk("wr_no_tx", 32'(txq_op.size()), 32'(t1));

    // fill the rest of set 3, touch 0x0013, then evict
    send(Op_READ, 16'h0033, '0);
    fill(32'h33333333, 0);
    chk("f33_data", rx.rsp_data, 32'h33333333);
    send(Op_READ, 16'h0043, '0);
    fill(32'h44444444, 1);
    chk("f43_data", rx.rsp_data, 32'h44444444);
    send(Op_READ, 16'h0013, '0);
    chk("touch_hit", 32'(rx.rsp_vld), 32'd1);
    c0 = cycles;
    send(Op_READ, 16'h0053, '0);
    chk("ev_wb_op", 32'(tx.req_op), 32'(Op_WRITE));
    chk("ev_wb_addr", 32'(tx.req_addr), 32'h0023);
    chk("ev_wb_data", tx.req_data, 32'h12345678);
    chk("ev_busy_wb", 32'(busy), 32'd1);
    cyc(1);
    chk("ev_rd_op", 32'(tx.req_op), 32'(Op_READ));
    chk("ev_rd_addr", 32'(tx.req_addr), 32'h0053);
    chk("ev_busy_fill", 32'(busy), 32'd1);
    cyc(1);
    chk("ev_busy_wait", 32'(busy), 32'd1);
    fill(32'h55555555, 0);
    chk("ev_rsp_vld", 32'(rx.rsp_vld), 32'd1);
    chk("ev_rsp_data", rx.rsp_data, 32'h55555555);
    chk("ev_latency", 32'(cycles - c0), 32'd4);

    // flush of two dirty lines in set 5
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    send(Op_WRITE, 16'h0005, 32'h55555555);
    chk("f5_tx_op", 32'(tx.req_op), 32'(Op_READ));
    fill(32'h11111111, 0);
    chk("f5_rsp", rx.rsp_data, 32'h55555555);
    send(Op_READ, 16'h00F5, '0);
    fill(32'h22222222, 0);
    chk("ff5_rsp", rx.rsp_data, 32'h22222222);
    send(Op_WRITE, 16'h00F5, 32'h66666666);
    chk("wh_rsp_vld", 32'(rx.rsp_vld), 32'd1);
    chk("wh_rsp_data", rx.rsp_data, 32'h66666666);
    t0 = txq_op.size();
    do_flush(n);
    chk("fl_cycles", 32'(n), 32'd65);
    chk("fl_nwrites", 32'(txq_op.size() - t0), 32'd2);
    if (txq_op.size() >= t0 + 2) begin
      chk("fl0_op", 32'(txq_op[t0]), 32'(Op_WRITE));
      chk("fl0_addr", 32'(txq_addr[t0]), 32'h0005);
      chk("fl0_data", txq_data[t0], 32'h55555555);
      chk("fl1_op", 32'(txq_op[t0+1]), 32'(Op_WRITE));
      chk("fl1_addr", 32'(txq_addr[t0+1]), 32'h00F5);
      chk("fl1_data", txq_data[t0+1], 32'h66666666);
    end
    cyc(1);
    chk("fl_done_pulse", 32'(flush_done), 32'd0);
    chk("fl_busy_end", 32'(busy), 32'd0);
    send(Op_READ, 16'h0005, '0);
    chk("fl_valid_vld", 32'(rx.rsp_vld), 32'd1);
    chk("fl_valid_data", rx.rsp_data, 32'h55555555);
    t0 = txq_op.size();
    do_flush(n);
    chk("fl2_cycles", 32'(n), 32'd65);
    chk("fl2_clean", 32'(txq_op.size()), 32'(t0));

    // reset during FILL abandons the miss
    cyc(1);
    send(Op_READ, 16'h0077, '0);
    chk("rf_tx_op", 32'(tx.req_op), 32'(Op_READ));
    cyc(1);
    rst_n = 1'b0;
    cyc(1);
    chk("rf_busy", 32'(busy), 32'd0);
    chk("rf_tx_idle", 32'(tx.req_op), 32'(Op_INVALID));
    rst_n = 1'b1;
    r0 = rxv_cnt;
    tx.rsp_vld  = 1'b1;
    tx.rsp_data = 32'hDEADBEEF;
    cyc(1);
    tx.rsp_vld  = 1'b0;
    cyc(2);
    chk("rf_no_rsp", 32'(rxv_cnt - r0), 32'd0);
    chk("rf_busy_after", 32'(busy), 32'd0);
    send(Op_READ, 16'h0005, '0);
    chk("rf_invalid_op", 32'(tx.req_op), 32'(Op_READ));
    chk("rf_invalid_addr", 32'(tx.req_addr), 32'h0005);
    fill(32'h0BAD0BAD, 0);
    chk("rf_refill", rx.rsp_data, 32'h0BAD0BAD);

    cyc(2);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/set_assoc_cache.md
SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 4: ways per set, power of two, 2..8.
REQ-002 SHALL have parameter INDEX_WIDTH, default 4: set-index bits (2^INDEX_WIDTH sets).
REQ-003 SHALL have parameter ADDR_WIDTH, default 16: address bits; TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH.
REQ-004 SHALL have parameter DATA_WIDTH, default 32: data word bits (one word per line).
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 rx_bp  MemBus  -  upstream side: req_op (Op), req_addr ADDR_WIDTH, req_data DATA_WIDTH in; rsp_vld 1, rsp_data DATA_WIDTH out.
REQ-008 tx_bp  MemBus  -  downstream side: req_op, req_addr, req_data out; rsp_vld 1, rsp_data DATA_WIDTH in.
REQ-009 flush_req  in  1  level request to write back all dirty lines.
REQ-010 flush_done  out  1  one-cycle pulse when flush completes.
REQ-011 busy  out  1  registered; high whenever state is not READY.

Function
REQ-012 SHALL split the address as tag = req_addr[ADDR_WIDTH-1:INDEX_WIDTH] and index = req_addr[INDEX_WIDTH-1:0].
REQ-013 SHALL use states READY, WRITEBACK, FILL and FLUSH; rx requests arriving outside READY SHALL be ignored.
REQ-014 In READY, a request (req_op != Op_INVALID) SHALL be captured and the tag compared against all ways of the set in the same cycle.
REQ-015 Read hit: rx rsp_vld SHALL pulse in the next cycle with the line data, and state SHALL remain READY.
REQ-016 Write hit: the line data SHALL be written and marked DIRTY, and rx rsp_vld SHALL pulse in the next cycle with rsp_data = written data.
REQ-017 Miss victim: the lowest-numbered INVALID way; if none is invalid, the way with age NUM_WAYS-1.
REQ-018 Miss with dirty victim: tx Op_WRITE SHALL be issued next cycle with {victim tag, index} and victim data, then WRITEBACK.
REQ-019 WRITEBACK SHALL last one cycle, then issue tx Op_READ of the captured address and go to FILL.
REQ-020 Miss with clean or invalid victim: tx Op_READ SHALL be issued next cycle and the state SHALL go to FILL.
REQ-021 Downstream writes are fire-and-forget; in FILL the block SHALL wait indefinitely for tx rsp_vld.
REQ-022 On tx rsp_vld in FILL, the victim SHALL be installed CLEAN with the filled data.
REQ-023 If the captured op is a write, that fill SHALL instead be installed DIRTY with the captured data.
REQ-024 After a fill, rx rsp_vld SHALL pulse next cycle (read: filled data; write: written data), and the state SHALL return to READY.
REQ-025 tx req_op SHALL be Op_INVALID in every cycle except the single issue cycles above.
REQ-026 Total read-miss latency SHALL be downstream latency + 2 cycles (clean victim) or + 3 cycles (dirty victim).
REQ-027 Ages are per set, each clog2(NUM_WAYS) bits, and update on every hit or fill of way w with age a.
REQ-028 On that update, ways with age < a SHALL increment and way w SHALL become 0, so ages always remain a permutation.
REQ-029 When an rx request and flush_req are both present in READY, the rx request SHALL win; flush SHALL start in READY with no rx request.
REQ-030 FLUSH SHALL scan (set, way) in index-major order, one entry per cycle.
REQ-031 Each DIRTY entry in the scan SHALL issue tx Op_WRITE and become CLEAN; tags, validity and ages SHALL be unchanged.
REQ-032 After the last entry, flush_done SHALL pulse and the state SHALL return to READY; a flush with no dirty lines takes 2^INDEX_WIDTH*NUM_WAYS cycles.
REQ-033 tx rsp_vld outside FILL SHALL be ignored.

Reset
REQ-034 On rst_n low, all lines SHALL be INVALID with tag/data 0, and ages SHALL equal the way number.
REQ-035 On rst_n low, state SHALL be READY and rx rsp_vld, rsp_data, flush_done and busy SHALL be 0.
REQ-036 On rst_n low, tx req_op SHALL be Op_INVALID and tx req_addr/req_data SHALL be 0.
REQ-037 Reset mid-miss or mid-flush SHALL abandon the operation with no response, and a late tx rsp_vld SHALL be ignored.

Structure
REQ-038 cache_pkg SHALL hold Op, Status and State (extended with State_FLUSH), plus the Line struct {status, tag, data} sized by package width constants.
REQ-039 Replacement age update and victim selection SHALL be one sub-module, cache_lru (one set's ages in, hit/fill way in, next ages and victim out).

Verification
REQ-040 After reset, a read of 0x0013 misses, issues tx READ 0x0013, and the fill returns 0xAAAA0001; rx rsp 0xAAAA0001 at fill+1, and a repeat read hits with a response 1 cycle later.
REQ-041 Write 0x0023 data 0x12345678 (miss, fill 0) -> line DIRTY; a read of 0x0023 returns 0x12345678 with no tx traffic.
REQ-042 Fill 0x0013, 0x0023, 0x0033, 0x0043 (set 3), touch 0x0013, then access 0x0053 -> victim is the way holding 0x0023.
REQ-043 With that victim dirty, the tx sequence SHALL be WRITE 0x0023 then READ 0x0053, with busy high throughout.
REQ-044 Dirty 0x0005 and 0x00F5, then pulse flush_req -> exactly two tx WRITEs in scan order and flush_done after 64 cycles; lines remain valid CLEAN.
REQ-045 Assert rst_n low during FILL, then drive tx rsp_vld -> no rx rsp_vld, all lines invalid, busy 0.
